// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// mstatus/mip bit positions and interrupt cause codes.
package csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  localparam int unsigned IRQ_CODE_SW  = 3;
  localparam int unsigned IRQ_CODE_TMR = 7;
  localparam int unsigned IRQ_CODE_EXT = 11;

  // Address decode result for the EX access.
  typedef struct packed {
    logic known;
    logic read_only;
  } csr_dec_t;

endpackage

// File: rtl/csr_counter.sv
// Wide free-running counter with per-half software write; a write to either
// half replaces only that half and holds off the increment for that cycle.
module csr_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned XLEN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned HI_W = CNT_W - XLEN;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo) begin
      cnt[XLEN-1:0] <= wdata;
    end else if (wr_hi) begin
      cnt[CNT_W-1:XLEN] <= HI_W'(wdata);
    end else if (inc_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: EX read-modify-write, cycle/instret counters,
// interrupt latching, trap entry / mret stacking and trap target generation.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 16,
  parameter int unsigned CNT_W       = 2 * XLEN,
  parameter bit          HAS_INSTRET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ex_op,
  input  logic [11:0]     ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  output logic [XLEN-1:0] ex_rdata,
  output logic            ex_illegal,
  input  logic            retire,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_tmr,
  input  logic            irq_sw,
  output logic            int_pending,
  output logic [XLEN-1:0] int_cause,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_o
);

  localparam int unsigned CODE_W = XLEN - 1;
  localparam logic [XLEN-1:0] MIE_WMASK =
    (XLEN'(1) << MIP_MSIP) | (XLEN'(1) << MIP_MTIP) | (XLEN'(1) << MIP_MEIP);
  localparam logic [XLEN-1:0] MEPC_MASK = ~XLEN'(1);

  logic            mst_mie;
  logic            mst_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mip_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mcause_q;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] irq_vec;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] pend;
  logic [XLEN-1:0] tvec_base;
  csr_dec_t        dec;
  logic            wr_attempt;
  logic            do_write;

  // Architectural views of mstatus and the raw interrupt lines.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mst_mie;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    irq_vec = '0;
    irq_vec[MIP_MEIP] = irq_ext;
    irq_vec[MIP_MTIP] = irq_tmr;
    irq_vec[MIP_MSIP] = irq_sw;
  end

  // Address decode and read mux.
  always_comb begin
    rdata = '0;
    dec   = '{known: 1'b0, read_only: 1'b0};
    case (ex_addr)
      CSR_MSTATUS:   begin rdata = mstatus_rd; dec.known = 1'b1; end
      CSR_MIE:       begin rdata = mie_q;      dec.known = 1'b1; end
      CSR_MIP:       begin rdata = mip_q;      dec.known = 1'b1; end
      CSR_MTVEC:     begin rdata = mtvec_q;    dec.known = 1'b1; end
      CSR_MSCRATCH:  begin rdata = mscratch_q; dec.known = 1'b1; end
      CSR_MEPC:      begin rdata = mepc_q;     dec.known = 1'b1; end
      CSR_MCAUSE:    begin rdata = mcause_q;   dec.known = 1'b1; end
      CSR_MCYCLE:    begin rdata = cycle_cnt[XLEN-1:0]; dec.known = 1'b1; end
      CSR_MCYCLEH:   begin rdata = XLEN'(cycle_cnt[CNT_W-1:XLEN]); dec.known = 1'b1; end
      CSR_MINSTRET: begin
        rdata = instret_cnt[XLEN-1:0];
        dec.known = 1'b1;
        dec.read_only = ~HAS_INSTRET;
      end
      CSR_MINSTRETH: begin
        rdata = XLEN'(instret_cnt[CNT_W-1:XLEN]);
        dec.known = 1'b1;
        dec.read_only = ~HAS_INSTRET;
      end
      CSR_CYCLE: begin
        rdata = cycle_cnt[XLEN-1:0];
        dec = '{known: 1'b1, read_only: 1'b1};
      end
      CSR_CYCLEH: begin
        rdata = XLEN'(cycle_cnt[CNT_W-1:XLEN]);
        dec = '{known: 1'b1, read_only: 1'b1};
      end
      CSR_INSTRET: begin
        rdata = instret_cnt[XLEN-1:0];
        dec = '{known: 1'b1, read_only: 1'b1};
      end
      CSR_INSTRETH: begin
        rdata = XLEN'(instret_cnt[CNT_W-1:XLEN]);
        dec = '{known: 1'b1, read_only: 1'b1};
      end
      default: ;
    endcase
  end

  // Set/clear with a zero mask is a pure read and never counts as a write.
  always_comb begin
    wr_attempt = (ex_op == CSR_OP_RW) ||
                 (((ex_op == CSR_OP_RS) || (ex_op == CSR_OP_RC)) && (|ex_wdata));
    ex_illegal = ~dec.known | (dec.read_only & wr_attempt);
    do_write   = wr_attempt & ~ex_illegal & ~trap_en;
    case (ex_op)
      CSR_OP_RW: wval = ex_wdata;
      CSR_OP_RS: wval = rdata | ex_wdata;
      CSR_OP_RC: wval = rdata & ~ex_wdata;
      default:   wval = rdata;
    endcase
  end

  assign ex_rdata = rdata;
  assign mepc_o   = mepc_q;

  // Highest-priority enabled interrupt: ext, then sw, then timer.
  always_comb begin
    pend        = mip_q & mie_q;
    int_pending = mst_mie & (|pend);
    int_cause   = '0;
    if (pend[MIP_MEIP]) begin
      int_cause = {1'b1, CODE_W'(IRQ_CODE_EXT)};
    end else if (pend[MIP_MSIP]) begin
      int_cause = {1'b1, CODE_W'(IRQ_CODE_SW)};
    end else if (pend[MIP_MTIP]) begin
      int_cause = {1'b1, CODE_W'(IRQ_CODE_TMR)};
    end
  end

  // Vectored mode offsets interrupts by 4*code from the aligned base.
  always_comb begin
    tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    trap_target = tvec_base;
    if ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1]) begin
      trap_target = tvec_base + {trap_cause[XLEN-3:0], 2'b00};
    end
  end

  // mstatus stacking: trap beats mret, and mret beats a software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
    end else if (trap_en) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (mret) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (do_write && (ex_addr == CSR_MSTATUS)) begin
      mst_mie  <= wval[MSTATUS_MIE];
      mst_mpie <= wval[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mip_q <= '0;
    end else begin
      mip_q <= irq_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
    end else if (trap_en) begin
      mepc_q   <= trap_pc & MEPC_MASK;
      mcause_q <= trap_cause;
    end else if (do_write) begin
      case (ex_addr)
        CSR_MIE:      mie_q      <= wval & MIE_WMASK;
        CSR_MTVEC:    mtvec_q    <= wval[1] ? {wval[XLEN-1:2], 2'b00} : wval;
        CSR_MEPC:     mepc_q     <= wval & MEPC_MASK;
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MCAUSE:   mcause_q   <= wval;
        default: ;
      endcase
    end
  end

  csr_counter #(
    .CNT_W (CNT_W),
    .XLEN  (XLEN)
  ) u_cycle (
    .clk    (clk),
    .rst    (rst),
    .inc_en (1'b1),
    .wr_lo  (do_write && (ex_addr == CSR_MCYCLE)),
    .wr_hi  (do_write && (ex_addr == CSR_MCYCLEH)),
    .wdata  (wval),
    .cnt    (cycle_cnt)
  );

  if (HAS_INSTRET) begin : g_instret
    csr_counter #(
      .CNT_W (CNT_W),
      .XLEN  (XLEN)
    ) u_instret (
      .clk    (clk),
      .rst    (rst),
      .inc_en (retire),
      .wr_lo  (do_write && (ex_addr == CSR_MINSTRET)),
      .wr_hi  (do_write && (ex_addr == CSR_MINSTRETH)),
      .wdata  (wval),
      .cnt    (instret_cnt)
    );
  end else begin : g_no_instret
    assign instret_cnt = '0;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR file for the OpenCPU core, replacing the fixed 16-bit CSR block. It executes CSRRW/CSRRS/CSRRC read-modify-write from EX, provides 64-bit-class cycle/instret counters, and latches interrupt inputs into mip. It performs trap entry and mret stacking of mstatus.MIE/MPIE and computes the trap target, including vectored mtvec. It sits beside EX and the interrupt controller and feeds the fetch redirect path.

## Interface
- XLEN, 16, data width; legal range 16 to 32.
- CNT_W, 2*XLEN, width of the cycle and instret counters; must equal 2*XLEN.
- HAS_INSTRET, 1, 0 removes the instret counter; its addresses then read 0 and writes are illegal.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ex_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- ex_addr  in  12  CSR address.
- ex_wdata  in  XLEN  write operand.
- ex_rdata  out  XLEN  old value of ex_addr; combinational.
- ex_illegal  out  1  unknown address, or a write attempt to a read-only address; combinational.
- retire  in  1  one instruction retired this cycle.
- trap_en  in  1  take a trap this cycle.
- trap_cause  in  XLEN  cause; MSB=1 means interrupt.
- trap_pc  in  XLEN  faulting or interrupted PC.
- mret  in  1  return from trap.
- irq_ext, irq_tmr, irq_sw  in  1 each  level interrupt requests.
- int_pending  out  1  mstatus.MIE & |(mip & mie).
- int_cause  out  XLEN  interrupt code to request.
- trap_target  out  XLEN  next PC on trap.
- mepc_o  out  XLEN  mepc, used by mret.

## Operation
- Registers: mstatus (MIE bit3, MPIE bit7, MPP bits12:11 read 2'b11, other bits read 0), mie, mip, mtvec, mepc, mscratch, mcause, mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82).
- User-mode aliases cycle/cycleh/instret/instreth (0xC00/0xC80/0xC02/0xC82) are read-only.
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata.
  - For RS/RC, ex_wdata==0 counts as no write and is never illegal.
- Write rules:
  - If ex_illegal is set, no write occurs.
  - mip is not writable by software; a write to it is legal but ignored.
  - mepc bit0 is forced to 0.
  - Only mie bits 3, 7 and 11 are writable.
- mip bits 11/7/3 = irq_ext/irq_tmr/irq_sw, registered once.
- int_cause priority: ext (code 11) > sw (3) > tmr (7); MSB set. When nothing is pending the code is 0.
- Trap entry:
  - mepc←{trap_pc[XLEN-1:1],0}, mcause←trap_cause.
  - MPIE←MIE, MIE←0.
- mret: MIE←MPIE, MPIE←1.
- trap_target:
  - mtvec[1:0]==01 and trap_cause MSB=1: {mtvec[XLEN-1:2],2'b00} + 4*cause[XLEN-2:0].
  - Otherwise: {mtvec[XLEN-1:2],2'b00}.
  - mtvec[1:0]==1x reads back as 00.
- Counters:
  - cycle increments every cycle; instret increments when retire=1.
  - Both wrap from all-ones to 0.
  - Writing a low or high half replaces only that half and suppresses the increment that cycle.

## Timing
- Reads, ex_illegal, int_cause and trap_target are combinational, with zero latency.
- CSR writes, trap and mret update registers at the next clk edge.
- An irq input reaches mip, and therefore int_pending, 1 cycle after it changes.
- Simultaneous events:
  - trap_en has priority and suppresses the EX write and mret in the same cycle.
  - mret together with an EX write: the EX write applies, except that mret's MIE/MPIE update wins over a write to mstatus.
  - retire together with an instret write: the write wins.
- Low-half increment carries into the high half in the same edge.
- Reset: all registers 0, counters 0, mip 0.
  - All outputs then read 0, except trap_target=0, ex_illegal per address, and mstatus MPP reads 2'b11.
  - Reset asserted mid-trap discards the trap.

## Structure
- Package csr_pkg holds:
  - CSR address constants and the op encodings (CSR_OP_NONE/RW/RS/RC);
  - mstatus/mip bit-position constants and interrupt cause codes.
- Sub-module csr_counter (CNT_W, XLEN) provides the counter with increment enable, half-select write and carry.
  - It is instantiated twice: cycle, and instret (the latter under HAS_INSTRET).

## Test plan
- Reset, then RS mstatus with 0x0008 → read 0x1808; RC with 0x0008 → 0x1800; RS with 0 → no write and no illegal.
- mtvec=0x0101, MIE=1, mie=0x0800, assert irq_ext → int_pending=1 after 1 cycle, int_cause=0x800B; trap with trap_pc=0x0123 → mepc=0x0122, MIE=0, MPIE=1, trap_target=0x012C.
- mret after that trap → MIE=1, MPIE=1; mret and RW mstatus=0 in the same cycle → MIE=1.
- Write mcycle=0xFFFF, mcycleh=0x0001 → after the next edges cycleh=0x0002, cycle=0x0000; write 0xC00 → ex_illegal=1 and no change.
- retire held for 5 cycles with a minstret write of 0x0010 in cycle 3 → final instret=0x0012; trap_en plus RW mscratch=0x55AA same cycle → mscratch unchanged.
